// File: rtl/serial_dev.sv
// serial_dev: memory-mapped 8N1 UART on the CPU device bus.
// Data port at BASE_ADDR, status port at BASE_ADDR+1. Received bytes are
// queued in a 4-entry FIFO. Status word: {12'h000, ferr, ovr, tx_busy, rx_avail}.
module serial_dev #(
    parameter logic [15:0] BASE_ADDR = 16'h0001,
    parameter int          CLK_DIV   = 16
) (
    input  logic        clk,
    input  logic        RST_bar,
    input  logic [15:0] addr,
    inout  wire  [15:0] bus,
    input  logic        DI,
    input  logic        DO,
    input  logic        rx,
    output logic        tx
);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Last cycle of a full bit, and last cycle of the half bit used to
    // reach the middle of the start bit.
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    logic        sel_d_s, sel_s_s;
    logic        wr_d_s, rd_d_s, rd_s_s;
    logic [1:0]  tx_state_r;
    logic [15:0] tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_r;
    logic        tx_busy_s;
    logic        rx_meta_r, rx_sync_r;
    logic [1:0]  rx_state_r;
    logic [15:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_push_s, rx_ferr_s;
    logic [7:0]  fifo_mem_r [4];
    logic [1:0]  fifo_wr_ptr_r, fifo_rd_ptr_r;
    logic [2:0]  fifo_count_r;
    logic        fifo_wr_s, fifo_rd_s, ovr_evt_s, rx_avail_s;
    logic        ferr_r, ovr_r;
    logic        bus_oe_s;
    logic [15:0] bus_out_s;

    // A cycle with both strobes high is no access at all.
    assign sel_d_s    = (addr == BASE_ADDR);
    assign sel_s_s    = (addr == (BASE_ADDR + 16'd1));
    assign wr_d_s     = DI & ~DO & sel_d_s;
    assign rd_d_s     = DO & ~DI & sel_d_s;
    assign rd_s_s     = DO & ~DI & sel_s_s;
    assign tx_busy_s  = (tx_state_r != TX_IDLE);
    assign rx_avail_s = (fifo_count_r != 3'd0);
    assign tx         = tx_r;

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit; tx is registered.
    always_ff @(posedge clk) begin
        if (!RST_bar) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= 16'd0;
                    tx_bit_r <= 3'd0;
                    if (wr_d_s) begin
                        tx_shift_r <= bus[7:0];
                        tx_r       <= 1'b0;
                        tx_state_r <= TX_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r   <= 16'd0;
                        tx_r       <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r <= 16'd0;
                        if (tx_bit_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_r       <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == DIV_LAST) begin
                        tx_cnt_r   <= 16'd0;
                        tx_state_r <= TX_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous rx line (idles high).
    always_ff @(posedge clk) begin
        if (!RST_bar) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM: verify start at mid-bit, then sample each bit at its middle.
    always_ff @(posedge clk) begin
        if (!RST_bar) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= 16'd0;
                    rx_bit_r <= 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= 16'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= 16'd0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == DIV_LAST) begin
                        rx_cnt_r   <= 16'd0;
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= 16'd0;
                end
            endcase
        end
    end

    // Mid-stop-bit sample decides between a good byte and a framing error.
    always_comb begin
        rx_push_s = 1'b0;
        rx_ferr_s = 1'b0;
        if ((rx_state_r == RX_STOP) && (rx_cnt_r == DIV_LAST)) begin
            rx_push_s = rx_sync_r;
            rx_ferr_s = ~rx_sync_r;
        end else begin
            rx_push_s = 1'b0;
            rx_ferr_s = 1'b0;
        end
    end

    // A push into a full FIFO is dropped; a pop from an empty FIFO is ignored.
    assign fifo_wr_s = rx_push_s & (fifo_count_r != 3'd4);
    assign ovr_evt_s = rx_push_s & (fifo_count_r == 3'd4);
    assign fifo_rd_s = rd_d_s & (fifo_count_r != 3'd0);

    // Receive FIFO storage/pointers plus sticky error flags (events beat clears).
    always_ff @(posedge clk) begin
        if (!RST_bar) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            fifo_wr_ptr_r <= 2'd0;
            fifo_rd_ptr_r <= 2'd0;
            fifo_count_r  <= 3'd0;
            ferr_r        <= 1'b0;
            ovr_r         <= 1'b0;
        end else begin
            if (fifo_wr_s) begin
                fifo_mem_r[fifo_wr_ptr_r] <= rx_shift_r;
                fifo_wr_ptr_r             <= fifo_wr_ptr_r + 2'd1;
            end
            if (fifo_rd_s) begin
                fifo_rd_ptr_r <= fifo_rd_ptr_r + 2'd1;
            end
            case ({fifo_wr_s, fifo_rd_s})
                2'b10:   fifo_count_r <= fifo_count_r + 3'd1;
                2'b01:   fifo_count_r <= fifo_count_r - 3'd1;
                default: fifo_count_r <= fifo_count_r;
            endcase
            ferr_r <= (ferr_r & ~rd_s_s) | rx_ferr_s;
            ovr_r  <= (ovr_r & ~rd_s_s) | ovr_evt_s;
        end
    end

    // Read data path onto the shared bus, valid in the same cycle as DO.
    always_comb begin
        bus_oe_s  = 1'b0;
        bus_out_s = 16'h0000;
        if (rd_d_s) begin
            bus_oe_s  = 1'b1;
            bus_out_s = rx_avail_s ? {8'h00, fifo_mem_r[fifo_rd_ptr_r]} : 16'h0000;
        end else if (rd_s_s) begin
            bus_oe_s  = 1'b1;
            bus_out_s = {12'h000, ferr_r, ovr_r, tx_busy_s, rx_avail_s};
        end else begin
            bus_oe_s  = 1'b0;
            bus_out_s = 16'h0000;
        end
    end

    assign bus = bus_oe_s ? bus_out_s : 16'hzzzz;

endmodule

// File: tb/tb_serial_dev.sv
// tb_serial_dev: scoreboard bench for serial_dev with CLK_DIV=4, BASE_ADDR=1.
// Expected RX bytes and TX bits are queued when stimulus is driven and
// compared when the device presents them. An undriven bus is pulled high.
module tb_serial_dev;

    localparam logic [15:0] BASE = 16'h0001;

    logic        clk     = 1'b0;
    logic        RST_bar = 1'b0;
    logic        DI      = 1'b0;
    logic        DO      = 1'b0;
    logic        rx      = 1'b1;
    logic [15:0] addr    = 16'h0000;
    logic [15:0] drv_val = 16'h0000;
    logic        drv_en  = 1'b0;
    wire  [15:0] bus;
    wire         tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q [$];
    bit         tx_q [$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    assign bus = drv_en ? drv_val : 16'hzzzz;
    pullup (bus);

    serial_dev #(.BASE_ADDR(16'h0001), .CLK_DIV(4)) dut (
        .clk     (clk),
        .RST_bar (RST_bar),
        .addr    (addr),
        .bus     (bus),
        .DI      (DI),
        .DO      (DO),
        .rx      (rx),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; drv_val = d; drv_en = 1'b1; DI = 1'b1;
        @(negedge clk);
        DI = 1'b0; drv_en = 1'b0;
    endtask

    task automatic read_status(input string tag);
        logic [15:0] exp;
        @(negedge clk);
        addr = BASE + 16'd1; DO = 1'b1;
        #1;
        exp = {12'h000, m_ferr, m_ovr, 1'b0, (rx_q.size() != 0)};
        check_value(tag, bus, exp);
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        @(negedge clk);
        DO = 1'b0;
    endtask

    task automatic read_data(input string tag);
        logic [15:0] exp;
        @(negedge clk);
        addr = BASE; DO = 1'b1;
        #1;
        if (rx_q.size() == 0) begin
            exp = 16'h0000;
        end else begin
            exp = {8'h00, rx_q.pop_front()};
        end
        check_value(tag, bus, exp);
        @(negedge clk);
        DO = 1'b0;
    endtask

    // Drive one 8N1 frame (4 cycles per bit) and update the receive model.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            rx = (k == 0) ? 1'b0 : ((k == 9) ? stop : b[k-1]);
            repeat (4) @(negedge clk);
        end
        rx = 1'b1;
        if (stop) begin
            if (rx_q.size() < 4) rx_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] wdata;
        bit          cur_bit;

        // 1. Reset
        repeat (3) @(negedge clk);
        check_value("reset_tx", {15'h0000, tx}, 16'h0001);
        check_value("reset_bus_z", bus, 16'hFFFF);
        RST_bar = 1'b1;
        read_status("reset_status");

        // 2. TX frame, second write during the frame ignored
        wdata = 16'h01A5;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(wdata[i]);
        tx_q.push_back(1'b1);
        bus_write(BASE, wdata);
        cur_bit = 1'b1;
        for (int j = 0; j < 48; j++) begin
            if (j > 0) @(negedge clk);
            DO      = (j == 0) || (j == 39) || (j == 40);
            addr    = DO ? (BASE + 16'd1) : BASE;
            DI      = (j == 10);
            drv_en  = (j == 10);
            drv_val = 16'h00FF;
            #1;
            if (j < 40) begin
                if ((j % 4) == 0) begin
                    if (tx_q.size() != 0) cur_bit = tx_q.pop_front();
                    else cur_bit = 1'b1;
                end
                check_value("tx_bit", {15'h0000, tx}, {15'h0000, cur_bit});
            end else begin
                check_value("tx_idle_after", {15'h0000, tx}, 16'h0001);
            end
            if (j == 0 || j == 39) check_value("tx_busy_status", bus, 16'h0002);
            if (j == 40) check_value("tx_done_status", bus, 16'h0000);
        end
        DO = 1'b0; DI = 1'b0; drv_en = 1'b0;

        // 3. RX receive
        send_frame(8'h3C, 1'b1);
        read_status("rx_status_avail");
        read_data("rx_data");
        read_status("rx_status_empty");

        // 4. FIFO order and overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        read_status("ovr_status");
        for (int i = 0; i < 5; i++) read_data("fifo_read");
        read_status("ovr_cleared");

        // 5. Framing error, then a false start, then a good frame
        send_frame(8'h55, 1'b0);
        read_status("ferr_status");
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (10) @(negedge clk);
        read_status("glitch_status");
        send_frame(8'h7E, 1'b1);
        read_data("after_glitch_data");

        // 6a. DI and DO together: no access
        @(negedge clk);
        addr = BASE; DI = 1'b1; DO = 1'b1;
        #1;
        check_value("collide_bus_z", bus, 16'hFFFF);
        @(negedge clk);
        DI = 1'b0; DO = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check_value("collide_tx_idle", {15'h0000, tx}, 16'h0001);
        end
        read_status("collide_status");

        // 6b. Reset in the middle of a frame
        bus_write(BASE, 16'h0000);
        repeat (10) @(negedge clk);
        check_value("midtx_low", {15'h0000, tx}, 16'h0000);
        RST_bar = 1'b0;
        @(negedge clk);
        check_value("midtx_reset_tx", {15'h0000, tx}, 16'h0001);
        RST_bar = 1'b1;
        read_status("midtx_reset_status");
        repeat (4) @(negedge clk);
        check_value("midtx_tx_stays", {15'h0000, tx}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_dev.md
# serial_dev

Memory-mapped UART peripheral on the CPU device bus, directly downstream of the CPU's device-I/O control lines. It consumes `DI` writes, transmitting the low byte as an 8N1 serial frame. It services `DO` reads by driving received bytes or status onto the shared 16-bit `bus`. Received bytes are buffered in a 4-entry FIFO so software polling can lag the line by several characters.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0001: device address of the data port; the status port is `BASE_ADDR+1`.
- `CLK_DIV`, 16: clock cycles per serial bit; even, ≥4.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `RST_bar`  in  1  reset, synchronous, active-low.
- `addr`  in  16  device address from CPU.
- `bus`  inout  16  shared CPU bus; driven only during a matching read, else `16'bZ`.
- `DI`  in  1  device-input strobe (CPU writes bus to device).
- `DO`  in  1  device-output strobe (device drives bus).
- `rx`  in  1  serial input, asynchronous, idle high.
- `tx`  out  1  serial output, idle high.

## Operation
- **Address decode:** `sel_d = (addr==BASE_ADDR)`, `sel_s = (addr==BASE_ADDR+1)`. Other addresses: no action, bus Z.
- **`DI` and `DO` both high:** treated as no access. No state change, bus Z.
- **Write data (`DI & sel_d`):**
  - If TX is idle, latch `bus[7:0]` and start a frame.
  - If TX is busy, the write is ignored.
  - Writes to the status port are ignored.
- **Read data (`DO & sel_d`):**
  - Combinationally drive `{8'h00, fifo_head}`.
  - At the posedge, pop one entry.
  - If the FIFO is empty, drive 16'h0000 and do not pop.
- **Read status (`DO & sel_s`):**
  - Drive `{12'h000, ferr, ovr, tx_busy, rx_avail}`.
  - At the posedge, clear `ferr` and `ovr`.
- **TX FSM (IDLE → START → DATA×8 → STOP → IDLE):**
  - Each bit lasts `CLK_DIV` cycles.
  - Data is sent LSB first.
  - `tx` is registered.
- **RX path:**
  - 2-flop synchroniser on `rx`.
  - **IDLE:** on sync'd low, go to START.
  - **START:** after `CLK_DIV/2` cycles, re-sample. If high, it was a false start → IDLE. Otherwise go to DATA.
  - **DATA:** sample every `CLK_DIV` cycles (mid-bit), 8 bits LSB first.
  - **STOP:** sample at mid-stop-bit.
    - Stop=1 → push byte.
    - Stop=0 → discard byte and set `ferr`.
  - Return to IDLE after the mid-stop sample.
- **FIFO:**
  - 4 entries, 2-bit read/write pointers, 3-bit count.
  - Push while full → byte dropped, `ovr` set.
  - Push and pop in the same cycle → both happen, count unchanged. If the FIFO was empty, the pop is suppressed and the push happens.
  - `rx_avail = (count != 0)`.
- **Flag update:** if a status read and a new `ferr`/`ovr` event fall in the same cycle, the flag ends set.

## Timing
- **Reset (`RST_bar` low at a posedge):**
  - `tx=1`, both FSMs IDLE, FIFO empty, all flags 0, bus Z.
  - Takes effect at that edge regardless of frame in progress. An aborted TX frame leaves `tx` high from the next cycle.
- **Bus drive:** combinational from `addr`/`DO`; valid in the same cycle the CPU samples it.
- **TX timing:**
  - A write accepted at edge k gives `tx=0` from edge k+1.
  - `tx_busy=1` from edge k+1 through the last cycle of the stop bit, for 10·`CLK_DIV` cycles total.
  - A new write is accepted at the first edge where `tx_busy` reads 0.
- **RX latency:** from the `rx` falling edge to the FIFO push is 2 (sync) + `CLK_DIV/2` + 9·`CLK_DIV` cycles, ±1.
- **Read/pop:** a byte pushed at edge n is readable (`rx_avail=1`) from edge n+1.

## Test plan
Each scenario uses `CLK_DIV=4`, `BASE_ADDR=16'h0001`.
1. **Reset:** hold `RST_bar` low for 3 cycles → `tx=1`; status read = 16'h0000; bus Z with `DO=0`.
2. **TX frame:** write 16'h1A5 to addr 1 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `tx_busy=1` for 40 cycles. A second write at cycle 10 is ignored: no second frame.
3. **RX receive:** drive 8N1 0x3C on `rx` → status reads 16'h0001. Data read returns 16'h003C. Status then reads 16'h0000.
4. **FIFO order and overrun:** send 0x01–0x05 with no reads → status = 16'h0005 (`ovr`, `rx_avail`). Reads return 01, 02, 03, 04, then 0000. The following status read = 16'h0000.
5. **Framing error and false start:**
   - Frame 0x55 with stop bit 0 → FIFO count 0, status = 16'h0008.
   - A 1-cycle low glitch on `rx` → no push, RX back to IDLE.
6. **Collisions:**
   - `DI` and `DO` high together at addr 1 → no TX start, bus Z.
   - Reset asserted mid-TX → `tx=1` on the next cycle and `tx_busy=0`.
